// File: rtl/uart_cmd_parser.sv
// Command-frame assembler fed by UART byte-done pulses: SYNC, OPCODE, LEN, payload, CHK.
// Accepted frames are held on a valid/ready interface; bad or stalled frames raise a one-cycle flag.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN      = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 4340
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_rx_done,
  input  logic [7:0]           i_rx_byte,
  output logic                 o_cmd_valid,
  input  logic                 i_cmd_ready,
  output logic [7:0]           o_cmd_opcode,
  output logic [7:0]           o_cmd_len,
  output logic [MAX_LEN*8-1:0] o_cmd_payload,
  output logic                 o_err_chk,
  output logic                 o_err_len,
  output logic                 o_err_timeout,
  output logic                 o_overrun
);

  localparam int unsigned TW      = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, OPCODE, LEN, PAYLOAD, CHECK, HOLD} state_t;

  state_t               state, state_n;
  logic [7:0]           opcode, opcode_n, len, len_n, idx, idx_n, chk, chk_n;
  logic [MAX_LEN*8-1:0] payload, payload_n;
  logic [TW-1:0]        timer, timer_n;
  logic                 valid, valid_n;
  logic                 err_chk, err_chk_n, err_len, err_len_n;
  logic                 err_to, err_to_n, overrun, overrun_n;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      opcode  <= '0;
      len     <= '0;
      idx     <= '0;
      chk     <= '0;
      payload <= '0;
      timer   <= '0;
      valid   <= 1'b0;
      err_chk <= 1'b0;
      err_len <= 1'b0;
      err_to  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_n;
      opcode  <= opcode_n;
      len     <= len_n;
      idx     <= idx_n;
      chk     <= chk_n;
      payload <= payload_n;
      timer   <= timer_n;
      valid   <= valid_n;
      err_chk <= err_chk_n;
      err_len <= err_len_n;
      err_to  <= err_to_n;
      overrun <= overrun_n;
    end
  end

  always_comb begin
    state_n   = state;
    opcode_n  = opcode;
    len_n     = len;
    idx_n     = idx;
    chk_n     = chk;
    payload_n = payload;
    timer_n   = '0;
    valid_n   = valid;
    err_chk_n = 1'b0;
    err_len_n = 1'b0;
    err_to_n  = 1'b0;
    overrun_n = 1'b0;

    // Inter-byte timer only runs mid-frame; a byte on the expiry cycle takes priority.
    if ((state inside {OPCODE, LEN, PAYLOAD, CHECK}) && !i_rx_done) begin
      if (timer == TO_LAST) begin
        err_to_n = 1'b1;
        state_n  = IDLE;
      end else begin
        timer_n = timer + TW'(1);
      end
    end

    case (state)
      IDLE: begin
        if (i_rx_done && i_rx_byte == SYNC_BYTE) begin
          state_n   = OPCODE;
          payload_n = '0;
          chk_n     = '0;
        end
      end
      OPCODE: begin
        if (i_rx_done) begin
          opcode_n = i_rx_byte;
          chk_n    = chk ^ i_rx_byte;
          state_n  = LEN;
        end
      end
      LEN: begin
        if (i_rx_done) begin
          if (i_rx_byte > MAX_LEN_B) begin
            err_len_n = 1'b1;
            state_n   = IDLE;
          end else begin
            len_n   = i_rx_byte;
            idx_n   = '0;
            chk_n   = chk ^ i_rx_byte;
            state_n = (i_rx_byte == 8'd0) ? CHECK : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (i_rx_done) begin
          for (int unsigned k = 0; k < MAX_LEN; k++) begin
            if (idx == 8'(k)) payload_n[8*k +: 8] = i_rx_byte;
          end
          chk_n = chk ^ i_rx_byte;
          idx_n = idx + 8'd1;
          if (idx == len - 8'd1) state_n = CHECK;
        end
      end
      CHECK: begin
        if (i_rx_done) begin
          if (i_rx_byte == chk) begin
            valid_n = 1'b1;
            state_n = HOLD;
          end else begin
            err_chk_n = 1'b1;
            state_n   = IDLE;
          end
        end
      end
      HOLD: begin
        if (i_rx_done) overrun_n = 1'b1;
        if (valid && i_cmd_ready) begin
          valid_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_cmd_valid   = valid;
  assign o_cmd_opcode  = opcode;
  assign o_cmd_len     = len;
  assign o_cmd_payload = payload;
  assign o_err_chk     = err_chk;
  assign o_err_len     = err_len;
  assign o_err_timeout = err_to;
  assign o_overrun     = overrun;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: expected frames/flags are queued as bytes are sent
// and matched against valid rising edges and error/overrun pulses.
module tb_uart_cmd_parser;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned TO      = 4340;
  localparam int K_FRAME = 1, K_CHK = 2, K_LEN = 3, K_TO = 4, K_OVR = 5, K_NONE = 0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 rx_done;
  logic [7:0]           rx_byte;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [7:0]           cmd_opcode;
  logic [7:0]           cmd_len;
  logic [MAX_LEN*8-1:0] cmd_payload;
  logic                 err_chk, err_len, err_timeout, overrun;

  typedef struct {
    int          kind;
    logic [7:0]  op;
    logic [7:0]  len;
    logic [63:0] pl;
  } evt_t;

  evt_t evq[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  uart_cmd_parser #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(8'hA5), .TIMEOUT_CLKS(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_done(rx_done), .i_rx_byte(rx_byte),
    .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_opcode(cmd_opcode),
    .o_cmd_len(cmd_len), .o_cmd_payload(cmd_payload), .o_err_chk(err_chk),
    .o_err_len(err_len), .o_err_timeout(err_timeout), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] op, input logic [7:0] len,
                      input logic [63:0] pl);
    evt_t e;
    e.kind = kind; e.op = op; e.len = len; e.pl = pl;
    evq.push_back(e);
  endtask

  task automatic observe(input int kind);
    evt_t e;
    if (evq.size() == 0) begin
      check("spurious_evt", 64'(kind), 64'(K_NONE));
    end else begin
      e = evq.pop_front();
      check("evt_kind", 64'(kind), 64'(e.kind));
      if (kind == K_FRAME && e.kind == K_FRAME) begin
        check("opcode", 64'(cmd_opcode), 64'(e.op));
        check("len", 64'(cmd_len), 64'(e.len));
        check("payload", 64'(cmd_payload), e.pl);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && !prev_valid) observe(K_FRAME);
      if (err_chk)     observe(K_CHK);
      if (err_len)     observe(K_LEN);
      if (err_timeout) observe(K_TO);
      if (overrun)     observe(K_OVR);
    end
    prev_valid = cmd_valid;
  end

  // Called at #1 after a rising edge; the byte is sampled on the next edge.
  task automatic send(input logic [7:0] b);
    rx_done = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
    rx_byte = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] len,
                            input logic [63:0] pl, input bit bad);
    logic [7:0]  c;
    logic [63:0] exp_pl;
    c = op ^ len;
    exp_pl = '0;
    for (int i = 0; i < int'(len); i++) begin
      c ^= pl[8*i +: 8];
      exp_pl[8*i +: 8] = pl[8*i +: 8];
    end
    if (bad) push(K_CHK, 8'h0, 8'h0, 64'h0);
    else     push(K_FRAME, op, len, exp_pl);
    send(8'hA5);
    send(op);
    send(len);
    for (int i = 0; i < int'(len); i++) send(pl[8*i +: 8]);
    send(bad ? (c ^ 8'h01) : c);
  endtask

  initial begin
    int n;
    logic [63:0] pl_hold;
    rst_n = 1'b0; rx_done = 1'b0; rx_byte = 8'h00; cmd_ready = 1'b1;
    #22;
    check("rst_valid", 64'(cmd_valid), 64'h0);
    check("rst_flags", 64'({err_chk, err_len, err_timeout, overrun}), 64'h0);
    check("rst_fields", 64'({cmd_opcode, cmd_len}), 64'h0);
    check("rst_payload", 64'(cmd_payload), 64'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(2);

    // Junk ignored, frame held while ready low, overrun during hold.
    cmd_ready = 1'b0;
    send(8'h00); send(8'hFF);
    send_frame(8'h10, 8'd2, 64'h2211, 1'b0);
    idle(1);
    check("hold_valid", 64'(cmd_valid), 64'h1);
    pl_hold = 64'(cmd_payload);
    check("hold_payload0", pl_hold, 64'h2211);
    for (int i = 0; i < 50; i++) begin
      idle(1);
      check("hold_stable", 64'({cmd_valid, cmd_opcode, cmd_len}), 64'({1'b1, 8'h10, 8'd2}));
      check("hold_payload", 64'(cmd_payload), 64'h2211);
    end
    push(K_OVR, 8'h0, 8'h0, 64'h0);
    send(8'hA5);
    idle(1);
    check("ovr_fields", 64'({cmd_valid, cmd_opcode, cmd_len}), 64'({1'b1, 8'h10, 8'd2}));
    check("ovr_payload", 64'(cmd_payload), 64'h2211);
    cmd_ready = 1'b1;
    check("pre_hs_valid", 64'(cmd_valid), 64'h1);
    idle(1);
    check("post_hs_valid", 64'(cmd_valid), 64'h0);

    // Zero-length frame after junk.
    send(8'h00); send(8'hFF);
    send_frame(8'h07, 8'd0, 64'h0, 1'b0);
    idle(3);

    // Bad checksum, then a good frame.
    send_frame(8'h10, 8'd2, 64'h2211, 1'b1);
    idle(3);
    check("chk_no_valid", 64'(cmd_valid), 64'h0);
    send_frame(8'h33, 8'd3, 64'hC0B0A0, 1'b0);
    idle(3);

    // Length errors, then maximum-length frame.
    push(K_LEN, 8'h0, 8'h0, 64'h0);
    send(8'hA5); send(8'h01); send(8'h09);
    idle(3);
    push(K_LEN, 8'h0, 8'h0, 64'h0);
    send(8'hA5); send(8'h01); send(8'hFF);
    idle(3);
    send_frame(8'h5A, 8'd8, 64'h8877665544332211, 1'b0);
    idle(3);

    // Timeout exactly TO edges after the last byte.
    push(K_TO, 8'h0, 8'h0, 64'h0);
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
    n = 0;
    while (n < int'(TO) + 20) begin
      @(posedge clk); #1; n++;
      if (err_timeout) break;
    end
    check("timeout_latency", 64'(n), 64'(TO));
    idle(3);

    // Byte on the final allowed cycle wins.
    push(K_FRAME, 8'h10, 8'd2, 64'h2211);
    send(8'hA5); send(8'h10); send(8'h02); send(8'h11);
    idle(int'(TO) - 1);
    send(8'h22); send(8'h10 ^ 8'h02 ^ 8'h11 ^ 8'h22);
    idle(3);

    // Overrun on the handshake cycle: byte dropped, parser returns to IDLE.
    cmd_ready = 1'b0;
    send_frame(8'h44, 8'd1, 64'h99, 1'b0);
    idle(2);
    push(K_OVR, 8'h0, 8'h0, 64'h0);
    cmd_ready = 1'b1;
    send(8'hA5);
    check("hs_ovr_valid", 64'(cmd_valid), 64'h0);
    send(8'h66);
    idle(3);
    send_frame(8'h21, 8'd1, 64'h42, 1'b0);
    idle(3);

    // Reset mid-payload clears everything; next frame accepted.
    send(8'hA5); send(8'h10); send(8'h04); send(8'h11); send(8'h22);
    check("pre_rst_payload", 64'(cmd_payload), 64'h2211);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(cmd_valid), 64'h0);
    check("mid_rst_payload", 64'(cmd_payload), 64'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);
    send_frame(8'h77, 8'd4, 64'hDEADBEEF, 1'b0);
    idle(4);

    check("pending_evts", 64'(evq.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
